// File: rtl/chess_input_conditioner.sv
// Purpose: synchronise, debounce and pulse-shape the board push-buttons and slide switches.
// Latency: raw edge sampled at edge t reaches the registered outputs at edge t+DEBOUNCE_CYCLES+2.
// Backpressure: none; free-running conditioner, every output is a registered level or 1-cycle pulse.
module chess_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 7_500_000
) (
    input  logic       clock,
    input  logic       globalReset,
    input  logic       KeyLeft,
    input  logic       KeyUp,
    input  logic       KeyDown,
    input  logic       KeyRight,
    input  logic       StartStopSwitch,
    input  logic       LockSwitch,
    output logic       moveLeft,
    output logic       moveUp,
    output logic       moveDown,
    output logic       moveRight,
    output logic [3:0] keyHeld,
    output logic       startStop,
    output logic       startStopToggle,
    output logic       lock
);

    localparam int RC_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DCW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCW     = $clog2(RC_SPAN + 1);

    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);
    localparam logic [RCW-1:0] RC_MAX  = '1;

    // Bit order {lock, start_stop, right, down, up, left}; keys idle high, switches idle low.
    localparam logic [5:0] SYNC_INIT = 6'b00_1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HOLD
    } key_state_t;

    logic [5:0] raw_in;
    logic [5:0] sync_a;
    logic [5:0] sync_b;
    logic [5:0] act;
    logic [5:0] deb;
    logic [3:0] move_nxt;
    logic       multi_held;

    assign raw_in = {LockSwitch, StartStopSwitch, KeyRight, KeyDown, KeyUp, KeyLeft};
    // Keys are inverted after the synchroniser so that 1 always means "active".
    assign act    = sync_b ^ SYNC_INIT;
    // More than one debounced key held: clearing the lowest set bit leaves something.
    assign multi_held = (deb[3:0] & (deb[3:0] - 4'd1)) != 4'd0;

    // Two-flop synchroniser, preset to the idle pin levels so reset release is silent.
    always_ff @(posedge clock or negedge globalReset) begin
        if (!globalReset) begin
            sync_a <= SYNC_INIT;
            sync_b <= SYNC_INIT;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_db
        logic [DCW-1:0] cnt;
        logic           lvl;

        assign deb[i] = lvl;

        // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
        always_ff @(posedge clock or negedge globalReset) begin
            if (!globalReset) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (act[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl <= ~lvl;
                cnt <= '0;
            end else begin
                cnt <= (cnt < DB_LAST) ? cnt + 1'b1 : cnt;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_state_t     st;
        key_state_t     st_nxt;
        logic [RCW-1:0] rc;
        logic [RCW-1:0] rc_nxt;
        logic           mv;
        logic           rise;
        logic           fall;

        // keyHeld is the one-cycle-delayed debounced level, so it doubles as the edge reference.
        assign rise        = deb[k] & ~keyHeld[k];
        assign fall        = ~deb[k] & keyHeld[k];
        assign move_nxt[k] = mv;

        // Key FSM state and repeat counter.
        always_ff @(posedge clock or negedge globalReset) begin
            if (!globalReset) begin
                st <= ST_IDLE;
                rc <= '0;
            end else begin
                st <= st_nxt;
                rc <= rc_nxt;
            end
        end

        // Next state: press pulse, delayed repeat, periodic repeat; release wins over a repeat.
        always_comb begin
            st_nxt = st;
            rc_nxt = (rc == RC_MAX) ? rc : rc + 1'b1;
            mv     = 1'b0;
            if (fall) begin
                st_nxt = ST_IDLE;
                rc_nxt = '0;
            end else begin
                case (st)
                    ST_IDLE: begin
                        rc_nxt = '0;
                        if (rise) begin
                            mv     = 1'b1;
                            st_nxt = multi_held ? ST_HOLD : ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (multi_held) begin
                            st_nxt = ST_HOLD;
                            rc_nxt = '0;
                        end else if (rc == RD_LAST) begin
                            mv     = 1'b1;
                            st_nxt = ST_REPEAT;
                            rc_nxt = '0;
                        end
                    end
                    ST_REPEAT: begin
                        if (multi_held) begin
                            st_nxt = ST_HOLD;
                            rc_nxt = '0;
                        end else if (rc == RP_LAST) begin
                            mv     = 1'b1;
                            rc_nxt = '0;
                        end
                    end
                    ST_HOLD: begin
                        // Parked until this key is released; a fresh press restarts repeat.
                        rc_nxt = '0;
                    end
                    default: begin
                        st_nxt = ST_IDLE;
                        rc_nxt = '0;
                    end
                endcase
            end
        end
    end

    // Registered outputs; levels and pulses leave on the same edge so they stay aligned.
    always_ff @(posedge clock or negedge globalReset) begin
        if (!globalReset) begin
            {moveRight, moveDown, moveUp, moveLeft} <= 4'b0000;
            keyHeld         <= 4'b0000;
            startStop       <= 1'b0;
            startStopToggle <= 1'b0;
            lock            <= 1'b0;
        end else begin
            {moveRight, moveDown, moveUp, moveLeft} <= move_nxt;
            keyHeld         <= deb[3:0];
            startStop       <= deb[4];
            startStopToggle <= deb[4] ^ startStop;
            lock            <= deb[5];
        end
    end

endmodule

// File: tb/tb_chess_input_conditioner.sv
module tb_chess_input_conditioner;

    logic       clock = 1'b0;
    logic       globalReset;
    logic       KeyLeft, KeyUp, KeyDown, KeyRight;
    logic       StartStopSwitch, LockSwitch;
    logic       moveLeft, moveUp, moveDown, moveRight;
    logic [3:0] keyHeld;
    logic       startStop, startStopToggle, lock;

    int checks = 0;
    int passes = 0;

    // {R,D,U,L moves}[10:7], keyHeld {R,D,U,L}[6:3], startStop[2], toggle[1], lock[0]
    wire [10:0] obs = {moveRight, moveDown, moveUp, moveLeft, keyHeld,
                       startStop, startStopToggle, lock};

    chess_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clock          (clock),
        .globalReset    (globalReset),
        .KeyLeft        (KeyLeft),
        .KeyUp          (KeyUp),
        .KeyDown        (KeyDown),
        .KeyRight       (KeyRight),
        .StartStopSwitch(StartStopSwitch),
        .LockSwitch     (LockSwitch),
        .moveLeft       (moveLeft),
        .moveUp         (moveUp),
        .moveDown       (moveDown),
        .moveRight      (moveRight),
        .keyHeld        (keyHeld),
        .startStop      (startStop),
        .startStopToggle(startStopToggle),
        .lock           (lock)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        KeyLeft = 1'b1; KeyUp = 1'b1; KeyDown = 1'b1; KeyRight = 1'b1;
        StartStopSwitch = 1'b0; LockSwitch = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        globalReset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clock);
        globalReset = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        exp = '0;
        idle_inputs();
        globalReset = 1'b1;
        #2 globalReset = 1'b0;
        #1;
        checks++;
        if (obs !== exp) $display("FAIL reset_state: got %b expected %b", obs, exp);
        else passes++;
        repeat (2) @(negedge clock);
        globalReset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clock); #1;
            checks++;
            if (obs !== exp) $display("FAIL reset_release edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_press();
        logic [10:0] exp;
        @(negedge clock);
        KeyLeft = 1'b0;
        for (int e = 0; e <= 15; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[7] = (e == 6);
            exp[3] = (e >= 6);
            checks++;
            if (obs !== exp) $display("FAIL press_left edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_glitch();
        logic [10:0] exp;
        exp = '0;
        @(negedge clock);
        KeyUp = 1'b0;
        for (int e = 0; e <= 15; e++) begin
            @(posedge clock); #1;
            if (e == 2) KeyUp = 1'b1;
            checks++;
            if (obs !== exp) $display("FAIL glitch_up edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_repeat();
        logic [10:0] exp;
        @(negedge clock);
        KeyRight = 1'b0;
        for (int e = 0; e <= 45; e++) begin
            @(posedge clock); #1;
            if (e == 29) KeyRight = 1'b1;
            exp = '0;
            exp[10] = (e == 6) || (e == 16) || (e == 19) || (e == 22) || (e == 25) ||
                      (e == 28) || (e == 31) || (e == 34);
            exp[6]  = (e >= 6) && (e <= 35);
            checks++;
            if (obs !== exp) $display("FAIL repeat_right edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_two_keys();
        logic [10:0] exp;
        @(negedge clock);
        KeyDown = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            @(posedge clock); #1;
            if (e == 4) KeyLeft = 1'b0;
            exp = '0;
            exp[9] = (e == 6);
            exp[7] = (e == 11);
            exp[5] = (e >= 6);
            exp[3] = (e >= 11);
            checks++;
            if (obs !== exp) $display("FAIL two_keys_held edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        KeyDown = 1'b1;
        KeyLeft = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[5] = (e < 6);
            exp[3] = (e < 6);
            checks++;
            if (obs !== exp) $display("FAIL two_keys_release edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_switches();
        logic [10:0] exp;
        @(negedge clock);
        StartStopSwitch = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[2] = (e >= 6);
            exp[1] = (e == 6);
            checks++;
            if (obs !== exp) $display("FAIL start_stop_on edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        LockSwitch = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[2] = 1'b1;
            exp[0] = (e >= 6);
            checks++;
            if (obs !== exp) $display("FAIL lock_on edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        StartStopSwitch = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[2] = (e < 6);
            exp[1] = (e == 6);
            exp[0] = 1'b1;
            checks++;
            if (obs !== exp) $display("FAIL start_stop_off edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [10:0] exp;
        @(negedge clock);
        KeyUp = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[8] = (e == 6) || (e == 16) || (e == 19);
            exp[4] = (e >= 6);
            checks++;
            if (obs !== exp) $display("FAIL pre_reset_up edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
        #2 globalReset = 1'b0;
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) $display("FAIL mid_reset_outputs: got %b expected %b", obs, exp);
        else passes++;
        repeat (2) @(negedge clock);
        globalReset = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clock); #1;
            exp = '0;
            exp[8] = (e == 6) || (e == 16) || (e == 19);
            exp[4] = (e >= 6);
            checks++;
            if (obs !== exp) $display("FAIL post_reset_up edge %0d: got %b expected %b", e, obs, exp);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        do_reset();
        test_glitch();
        do_reset();
        test_repeat();
        do_reset();
        test_two_keys();
        do_reset();
        test_switches();
        do_reset();
        test_reset_mid_repeat();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
